// File: rtl/fp_square.sv
// fp_square: IEEE-754 single-precision squaring unit, z = a * a.
// Multi-cycle datapath behind a stb/ack operand/result handshake.
// Ports:
//   CLK          - clock, rising edge
//   RST          - asynchronous active-low reset
//   input_a      - operand (float32), input_a_stb valid, input_a_ack ready
//   output_z     - result (float32), output_z_stb valid, output_z_ack taken
// Sign is discarded (squares are non-negative); denormal inputs and
// underflowed results flush to zero, overflow saturates to +Inf.
module fp_square (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned E_W    = 10;

  localparam logic [2:0] GET_A     = 3'd0;
  localparam logic [2:0] UNPACK    = 3'd1;
  localparam logic [2:0] SPECIAL   = 3'd2;
  localparam logic [2:0] MULTIPLY  = 3'd3;
  localparam logic [2:0] NORMALISE = 3'd4;
  localparam logic [2:0] ROUND     = 3'd5;
  localparam logic [2:0] PACK      = 3'd6;
  localparam logic [2:0] PUT_Z     = 3'd7;

  localparam logic [WORD_W-1:0] Z_NAN  = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] Z_INF  = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] Z_ZERO = 32'h0000_0000;

  logic [2:0]              state_q, state_d;
  logic [WORD_W-2:0]       a_q, a_d;
  logic [EXP_W-1:0]        ea_q, ea_d;
  logic [MAN_W-1:0]        m_q, m_d;
  logic [PROD_W-1:0]       p_q, p_d;
  logic signed [E_W-1:0]   e_q, e_d;
  logic [MAN_W-1:0]        mant_q, mant_d;
  logic                    guard_q, guard_d;
  logic                    rnd_q, rnd_d;
  logic                    sticky_q, sticky_d;
  logic [WORD_W-1:0]       z_q, z_d;
  logic                    a_ack_q, a_ack_d;
  logic                    z_stb_q, z_stb_d;
  logic [MAN_W:0]          rounded;

  // Operand sign never affects a square.
  logic unused_sign;
  assign unused_sign = input_a[31];

  assign input_a_ack  = a_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= GET_A;
      a_q      <= '0;
      ea_q     <= '0;
      m_q      <= '0;
      p_q      <= '0;
      e_q      <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      rnd_q    <= 1'b0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      a_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      ea_q     <= ea_d;
      m_q      <= m_d;
      p_q      <= p_d;
      e_q      <= e_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      rnd_q    <= rnd_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      a_ack_q  <= a_ack_d;
      z_stb_q  <= z_stb_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    ea_d     = ea_q;
    m_d      = m_q;
    p_d      = p_q;
    e_d      = e_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    rnd_d    = rnd_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    a_ack_d  = a_ack_q;
    z_stb_d  = z_stb_q;
    rounded  = {1'b0, mant_q} + (MAN_W+1)'(1);

    case (state_q)
      GET_A: begin
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a[WORD_W-2:0];
          a_ack_d = 1'b0;
          state_d = UNPACK;
        end else begin
          a_ack_d = 1'b1;
        end
      end

      UNPACK: begin
        ea_d    = a_q[30:23];
        m_d     = {(a_q[30:23] != 8'd0), a_q[22:0]};
        state_d = SPECIAL;
      end

      SPECIAL: begin
        if (ea_q == 8'hFF) begin
          z_d     = (a_q[22:0] != 23'd0) ? Z_NAN : Z_INF;
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else if (ea_q == 8'd0) begin
          z_d     = Z_ZERO;
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else begin
          state_d = MULTIPLY;
        end
      end

      MULTIPLY: begin
        p_d     = PROD_W'(m_q) * PROD_W'(m_q);
        // 2*ea - bias, kept signed so underflow stays visible.
        e_d     = $signed({1'b0, ea_q, 1'b0}) - 10'sd127;
        state_d = NORMALISE;
      end

      NORMALISE: begin
        if (p_q[47]) begin
          e_d      = e_q + 10'sd1;
          mant_d   = p_q[47:24];
          guard_d  = p_q[23];
          rnd_d    = p_q[22];
          sticky_d = |p_q[21:0];
        end else begin
          mant_d   = p_q[46:23];
          guard_d  = p_q[22];
          rnd_d    = p_q[21];
          sticky_d = |p_q[20:0];
        end
        state_d = ROUND;
      end

      ROUND: begin
        // Round to nearest, ties to even.
        if (guard_q && (rnd_q || sticky_q || mant_q[0])) begin
          if (rounded[MAN_W]) begin
            mant_d = 24'h80_0000;
            e_d    = e_q + 10'sd1;
          end else begin
            mant_d = rounded[MAN_W-1:0];
          end
        end
        state_d = PACK;
      end

      PACK: begin
        if (e_q >= 10'sd255) begin
          z_d = Z_INF;
        end else if (e_q <= 10'sd0) begin
          z_d = Z_ZERO;
        end else begin
          z_d = {1'b0, e_q[7:0], mant_q[22:0]};
        end
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end

      PUT_Z: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          a_ack_d = 1'b1;
          state_d = GET_A;
        end
      end

      default: begin
        state_d = GET_A;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_square.sv
// Directed bench for fp_square: reset, normal squares, rounding, specials,
// range limits, backpressure, back-to-back operands and mid-op reset.
module tb_fp_square;

  logic        CLK;
  logic        RST;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int errors = 0;
  int checks = 0;

  fp_square dut (
    .CLK          (CLK),
    .RST          (RST),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one operand and takes the result; lat counts edges after E0 until stb.
  task automatic do_op(input logic [31:0] a, output int lat, output logic [31:0] z);
    int n;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (input_a_ack !== 1'b1) begin
      lat = -1;
      z   = 32'hDEAD_BEEF;
      return;
    end
    input_a     = a;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    z = output_z;
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    checks++;
    if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", input_a_ack); end
    checks++;
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", output_z_stb); end
    checks++;
    if (output_z !== 32'h0) begin errors++; $display("FAIL reset_z: got %h want 00000000", output_z); end
    RST = 1'b1;
    tick();
    checks++;
    if (input_a_ack !== 1'b1) begin errors++; $display("FAIL reset_ack_rise: got %b want 1", input_a_ack); end
  endtask

  task automatic test_vectors(input string name, input logic [31:0] va [],
                              input logic [31:0] vz [], input int vl []);
    int lat;
    logic [31:0] z;
    for (int i = 0; i < va.size(); i++) begin
      do_op(va[i], lat, z);
      checks++;
      if (z !== vz[i]) begin
        errors++;
        $display("FAIL %s_z[%0d] a=%h: got %h want %h", name, i, va[i], z, vz[i]);
      end
      checks++;
      if (lat != vl[i]) begin
        errors++;
        $display("FAIL %s_lat[%0d] a=%h: got %0d want %0d", name, i, va[i], lat, vl[i]);
      end
    end
  endtask

  task automatic test_normal();
    test_vectors("normal", '{32'h4040_0000, 32'hC000_0000},
                 '{32'h4110_0000, 32'h4080_0000}, '{6, 6});
  endtask

  task automatic test_rounding();
    test_vectors("round", '{32'h3F80_0001, 32'h3FB5_04F3},
                 '{32'h3F80_0002, 32'h3FFF_FFFF}, '{6, 6});
  endtask

  task automatic test_specials();
    test_vectors("special", '{32'h7FC0_0001, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001},
                 '{32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000},
                 '{2, 2, 2, 2});
  endtask

  task automatic test_range();
    test_vectors("range", '{32'h7F7F_FFFF, 32'h0DA2_4260},
                 '{32'h7F80_0000, 32'h0000_0000}, '{6, 6});
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 20) begin tick(); n++; end
    input_a     = 32'h4040_0000;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    n = 0;
    while (output_z_stb !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 6) begin errors++; $display("FAIL bp_lat: got %0d want 6", n); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (output_z_stb !== 1'b1 || output_z !== 32'h4110_0000 || input_a_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL bp_release_stb: got %b want 0", output_z_stb); end
    checks++;
    if (input_a_ack !== 1'b1) begin errors++; $display("FAIL bp_release_ack: got %b want 1", input_a_ack); end
    checks++;
    if (output_z !== 32'h4110_0000) begin errors++; $display("FAIL bp_z_keep: got %h want 41100000", output_z); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] z1;
    logic [31:0] z2;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 20) begin tick(); n++; end
    input_a     = 32'h4000_0000;
    input_a_stb = 1'b1;
    tick();
    input_a = 32'h4040_0000;
    n = 0;
    while (output_z_stb !== 1'b1 && n < 40) begin tick(); n++; end
    z1 = output_z;
    output_z_ack = 1'b1;
    tick();
    n++;
    output_z_ack = 1'b0;
    while (output_z_stb !== 1'b1 && n < 80) begin tick(); n++; end
    input_a_stb = 1'b0;
    z2 = output_z;
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    checks++;
    if (z1 !== 32'h4080_0000) begin errors++; $display("FAIL b2b_first: got %h want 40800000", z1); end
    checks++;
    if (z2 !== 32'h4110_0000) begin errors++; $display("FAIL b2b_second: got %h want 41100000", z2); end
    checks++;
    if (n != 14) begin errors++; $display("FAIL b2b_cycles: got %0d want 14", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    int lat;
    logic [31:0] z;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 20) begin tick(); n++; end
    input_a     = 32'h4040_0000;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    tick();
    tick();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if (input_a_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b want 0", input_a_ack); end
    checks++;
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL midrst_stb: got %b want 0", output_z_stb); end
    checks++;
    if (output_z !== 32'h0) begin errors++; $display("FAIL midrst_z: got %h want 00000000", output_z); end
    tick();
    tick();
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (output_z_stb !== 1'b0 || output_z !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_no_result: got %0d bad cycles want 0", bad); end
    do_op(32'h4000_0000, lat, z);
    checks++;
    if (z !== 32'h4080_0000) begin errors++; $display("FAIL midrst_next_z: got %h want 40800000", z); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL midrst_next_lat: got %0d want 6", lat); end
  endtask

  initial begin
    RST          = 1'b0;
    input_a      = 32'h0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    #1;
    test_reset();
    test_normal();
    test_rounding();
    test_specials();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
